// File: rtl/wave_display_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : wave_display_multi_if
// Purpose  : Pixel-in, sample-RAM and colour-out bundle for wave_display_multi.
// Revision : 1.0
// ============================================================================
interface wave_display_multi_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int COL_W    = 8
);
  logic [10:0]                x;
  logic [9:0]                 y;
  logic                       valid;
  logic [1:0]                 mode;
  logic [NUM_CH-1:0]          ch_enable;
  logic                       read_index;
  logic [COL_W:0]             read_address;
  logic [NUM_CH*SAMPLE_W-1:0] read_value;
  logic                       valid_pixel;
  logic [7:0]                 r;
  logic [7:0]                 g;
  logic [7:0]                 b;

  modport master (
    output x, y, valid, mode, ch_enable, read_index, read_value,
    input  read_address, valid_pixel, r, g, b
  );

  modport slave (
    input  x, y, valid, mode, ch_enable, read_index, read_value,
    output read_address, valid_pixel, r, g, b
  );
endinterface
`default_nettype wire

// File: rtl/wave_display_multi.sv
`default_nettype none
// ============================================================================
// Module   : wave_display_multi
// Purpose  : Multi-channel dot / line / AA-line waveform renderer, 3-stage pipe.
// Revision : 1.0
// ============================================================================
module wave_display_multi #(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_W     = 8,
  parameter int WAVE_H_LOG2  = 8,
  parameter int COL_W        = 8,
  parameter int SAMPLE_SHIFT = 1,
  parameter int X_START      = 256,
  parameter int Y_TOP        = 0
) (
  input wire                  clk,
  input wire                  reset,
  wave_display_multi_if.slave bus
);

  localparam logic [31:0] c_x_lo     = 32'(X_START);
  localparam logic [31:0] c_x_span   = 32'(2**(COL_W + SAMPLE_SHIFT));
  localparam logic [31:0] c_y_lo     = 32'(Y_TOP);
  localparam logic [31:0] c_y_span   = 32'(2**WAVE_H_LOG2);
  localparam logic [31:0] c_y_bottom = 32'(Y_TOP + 2**WAVE_H_LOG2 - 1);
  localparam int          c_smp_sh   = SAMPLE_W - WAVE_H_LOG2;
  localparam logic [1:0]  c_mode_dot  = 2'd0;
  localparam logic [1:0]  c_mode_line = 2'd1;
  localparam logic [1:0]  c_mode_aa   = 2'd2;

  function automatic logic [31:0] trace_row(input logic [SAMPLE_W-1:0] s);
    return c_y_bottom - 32'(s >> c_smp_sh);
  endfunction

  function automatic logic [23:0] palette(input int k);
    case (k)
      0:       return 24'h00FF00;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      default: return 24'hFF00FF;
    endcase
  endfunction

  function automatic logic [7:0] sat8(input logic [9:0] a);
    return (a > 10'd255) ? 8'hFF : a[7:0];
  endfunction

  // Offsets wrap to huge values below the region, so one compare covers both bounds
  logic [31:0]      w_dx;
  logic [31:0]      w_dy;
  logic             w_region;
  logic [COL_W-1:0] w_col;

  assign w_dx     = 32'(bus.x) - c_x_lo;
  assign w_dy     = 32'(bus.y) - c_y_lo;
  assign w_region = (w_dx < c_x_span) && (w_dy < c_y_span);
  assign w_col    = COL_W'(w_dx >> SAMPLE_SHIFT);

  logic [9:0]        r1_y, r2_y;
  logic              r1_valid, r2_valid;
  logic              r1_region, r2_region;
  logic [1:0]        r1_mode, r2_mode;
  logic [NUM_CH-1:0] r1_en, r2_en;
  logic [COL_W-1:0]  r1_col, r2_col;
  logic [COL_W:0]    r_read_address;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_y <= '0; r1_valid <= 1'b0; r1_region <= 1'b0; r1_mode <= '0; r1_en <= '0; r1_col <= '0;
      r2_y <= '0; r2_valid <= 1'b0; r2_region <= 1'b0; r2_mode <= '0; r2_en <= '0; r2_col <= '0;
      r_read_address <= '0;
    end else begin
      r1_y      <= bus.y;
      r1_valid  <= bus.valid;
      r1_region <= w_region;
      r1_mode   <= bus.mode;
      r1_en     <= bus.ch_enable;
      r1_col    <= w_col;
      if (w_region) begin
        r_read_address <= {bus.read_index, w_col};
      end
      r2_y      <= r1_y;
      r2_valid  <= r1_valid;
      r2_region <= r1_region;
      r2_mode   <= r1_mode;
      r2_en     <= r1_en;
      r2_col    <= r1_col;
    end
  end

  logic [SAMPLE_W-1:0] r_cur  [NUM_CH];
  logic [SAMPLE_W-1:0] r_prev [NUM_CH];
  logic [COL_W-1:0]    r_last_col;
  logic                r_have_prev;
  logic                r_valid_pixel;
  logic [7:0]          r_r, r_g, r_b;

  logic [SAMPLE_W-1:0] w_cur   [NUM_CH];
  logic [SAMPLE_W-1:0] w_prev  [NUM_CH];
  logic [31:0]         w_row_c [NUM_CH];
  logic [31:0]         w_row_p [NUM_CH];
  logic [31:0]         w_lo    [NUM_CH];
  logic [31:0]         w_hi    [NUM_CH];
  logic [NUM_CH-1:0]   w_full;
  logic [NUM_CH-1:0]   w_half;
  logic [23:0]         w_pal;
  logic [9:0]          w_acc_r, w_acc_g, w_acc_b;
  logic [31:0]         w_y;
  logic                w_restart;
  logic                w_new_col;
  logic                w_live;

  assign w_y       = 32'(r2_y);
  assign w_live    = r2_valid & r2_region;
  // Column 0 and the first pixel after reset have no left neighbour
  assign w_restart = (r2_col == '0) || !r_have_prev;
  assign w_new_col = (r2_col != r_last_col);

  always_comb begin
    w_full  = '0;
    w_half  = '0;
    w_pal   = '0;
    w_acc_r = '0;
    w_acc_g = '0;
    w_acc_b = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cur[k]   = bus.read_value[k*SAMPLE_W +: SAMPLE_W];
      w_prev[k]  = w_restart ? w_cur[k] : (w_new_col ? r_cur[k] : r_prev[k]);
      w_row_c[k] = trace_row(w_cur[k]);
      w_row_p[k] = trace_row(w_prev[k]);
      w_lo[k]    = (w_row_p[k] < w_row_c[k]) ? w_row_p[k] : w_row_c[k];
      w_hi[k]    = (w_row_p[k] < w_row_c[k]) ? w_row_c[k] : w_row_p[k];
      if (r2_en[k]) begin
        case (r2_mode)
          c_mode_dot:  w_full[k] = (w_y == w_row_c[k]);
          c_mode_line: w_full[k] = (w_y >= w_lo[k]) && (w_y <= w_hi[k]);
          c_mode_aa: begin
            w_full[k] = (w_y >= w_lo[k]) && (w_y <= w_hi[k]);
            w_half[k] = !w_full[k] && ((w_y == w_lo[k] - 32'd1) || (w_y == w_hi[k] + 32'd1));
          end
          default: ;
        endcase
      end
      w_pal = palette(k);
      if (w_full[k]) begin
        w_acc_r = w_acc_r + 10'(w_pal[23:16]);
        w_acc_g = w_acc_g + 10'(w_pal[15:8]);
        w_acc_b = w_acc_b + 10'(w_pal[7:0]);
      end else if (w_half[k]) begin
        w_acc_r = w_acc_r + 10'(w_pal[23:17]);
        w_acc_g = w_acc_g + 10'(w_pal[15:9]);
        w_acc_b = w_acc_b + 10'(w_pal[7:1]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_cur[k]  <= '0;
        r_prev[k] <= '0;
      end
      r_last_col    <= '0;
      r_have_prev   <= 1'b0;
      r_valid_pixel <= 1'b0;
      r_r <= '0; r_g <= '0; r_b <= '0;
    end else begin
      r_valid_pixel <= w_live;
      r_r <= w_live ? sat8(w_acc_r) : 8'h00;
      r_g <= w_live ? sat8(w_acc_g) : 8'h00;
      r_b <= w_live ? sat8(w_acc_b) : 8'h00;
      if (w_live) begin
        for (int k = 0; k < NUM_CH; k++) begin
          r_cur[k]  <= w_cur[k];
          r_prev[k] <= w_prev[k];
        end
        r_last_col  <= r2_col;
        r_have_prev <= 1'b1;
      end
    end
  end

  assign bus.read_address = r_read_address;
  assign bus.valid_pixel  = r_valid_pixel;
  assign bus.r            = r_r;
  assign bus.g            = r_g;
  assign bus.b            = r_b;

endmodule
`default_nettype wire

// File: tb/tb_wave_display_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_display_multi
// Purpose  : Scoreboard bench for wave_display_multi (NUM_CH=2, default geometry).
// Revision : 1.0
// ============================================================================
module tb_wave_display_multi;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] ram0 [512];
  logic [7:0] ram1 [512];

  typedef struct {
    int         due;
    bit         chk;
    logic       vp;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         id;
  } exp_t;

  exp_t sb[$];

  wave_display_multi_if #(.NUM_CH(2), .SAMPLE_W(8), .COL_W(8)) bus ();

  wave_display_multi #(
    .NUM_CH(2), .SAMPLE_W(8), .WAVE_H_LOG2(8), .COL_W(8),
    .SAMPLE_SHIFT(1), .X_START(256), .Y_TOP(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.read_value <= {ram1[bus.read_address], ram0[bus.read_address]};

  task automatic drive(input int px, input int py, input bit pv, input int pm,
                       input logic [1:0] pen, input bit pri, input bit chk,
                       input logic evp, input logic [23:0] ergb, input int id);
    bus.x = 11'(px); bus.y = 10'(py); bus.valid = pv;
    bus.mode = 2'(pm); bus.ch_enable = pen; bus.read_index = pri;
    sb.push_back('{due: cyc + 3, chk: chk, vp: evp, r: ergb[23:16], g: ergb[15:8], b: ergb[7:0], id: id});
  endtask

  task automatic idle();
    bus.valid = 1'b0; bus.x = 11'd0; bus.y = 10'd0;
  endtask

  task automatic fill(input int lo, input int hi, input logic [7:0] v0, input logic [7:0] v1);
    for (int a = lo; a <= hi; a++) begin ram0[a] = v0; ram1[a] = v1; end
  endtask

  task automatic test_reset();
    exp_t e;
    fill(0, 511, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.valid_pixel !== 1'b0 || {bus.r, bus.g, bus.b} !== 24'h0 || bus.read_address !== 9'h0) begin
      n_bad++;
      $display("FAIL reset_state: vp=%b rgb=%06x addr=%03x, want all 0", bus.valid_pixel, {bus.r, bus.g, bus.b}, bus.read_address);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(300, 255, 1'b1, 0, 2'b01, 1'b0, 1'b0, 1'b1, 24'h00FF00, i);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.valid_pixel !== 1'b0 || {bus.r, bus.g, bus.b} !== 24'h0 || bus.read_address !== 9'h0) begin
      n_bad++;
      $display("FAIL reset_async: vp=%b rgb=%06x addr=%03x, want all 0", bus.valid_pixel, {bus.r, bus.g, bus.b}, bus.read_address);
    end
    @(negedge clk);
    sb.delete();
    reset = 1'b0;
    drive(300, 10, 1'b1, 0, 2'b01, 1'b0, 1'b1, 1'b1, 24'h000000, 100);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_cmp++;
        if (bus.read_address !== 9'h016 || bus.valid_pixel !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_addr_latency: addr=%03x vp=%b, want addr=016 vp=0", bus.read_address, bus.valid_pixel);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (bus.valid_pixel !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_vp_latency: vp=%b after 2 edges, want 0", bus.valid_pixel);
        end
      end
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.chk) begin
          n_cmp++;
          if (e.due != cyc || bus.valid_pixel !== e.vp || {bus.r, bus.g, bus.b} !== {e.r, e.g, e.b}) begin
            n_bad++;
            $display("FAIL reset_first_pixel id=%0d: got vp=%b rgb=%06x, want vp=%b rgb=%06x", e.id, bus.valid_pixel, {bus.r, bus.g, bus.b}, e.vp, {e.r, e.g, e.b});
          end
        end
      end
      idle();
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL reset_drain: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_dot_ramp();
    exp_t e;
    bit   in_r;
    int   col;
    for (int a = 0; a < 512; a++) begin ram0[a] = 8'(a); ram1[a] = 8'd0; end
    for (int i = 0; i < 2052; i++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.chk) begin
          n_cmp++;
          if (e.due != cyc || bus.valid_pixel !== e.vp || {bus.r, bus.g, bus.b} !== {e.r, e.g, e.b}) begin
            n_bad++;
            $display("FAIL dot_ramp x=%0d: got vp=%b rgb=%06x, want vp=%b rgb=%06x", e.id, bus.valid_pixel, {bus.r, bus.g, bus.b}, e.vp, {e.r, e.g, e.b});
          end
        end
      end
      if (i < 2048) begin
        in_r = (i >= 256) && (i <= 767);
        col  = (i - 256) / 2;
        drive(i, 128, 1'b1, 0, 2'b01, 1'b0, 1'b1, in_r,
              (in_r && (255 - col == 128)) ? 24'h00FF00 : 24'h000000, i);
      end else begin
        idle();
      end
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL dot_ramp_drain: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_line_step();
    exp_t        e;
    int          px [7] = '{274, 276, 274, 276, 767, 256, 256};
    int          py [7] = '{100, 100, 100, 100, 100, 100, 255};
    int          pm [7] = '{1, 1, 0, 0, 1, 1, 1};
    bit          ck [7] = '{0, 1, 0, 1, 0, 1, 1};
    logic [23:0] ex [7] = '{24'h0, 24'h00FF00, 24'h0, 24'h000000, 24'h0, 24'h000000, 24'h00FF00};
    ram0[9] = 8'd0; ram0[10] = 8'd255; ram0[0] = 8'd0; ram0[255] = 8'd255;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.chk) begin
          n_cmp++;
          if (e.due != cyc || bus.valid_pixel !== e.vp || {bus.r, bus.g, bus.b} !== {e.r, e.g, e.b}) begin
            n_bad++;
            $display("FAIL line_step #%0d: got vp=%b rgb=%06x, want vp=%b rgb=%06x", e.id, bus.valid_pixel, {bus.r, bus.g, bus.b}, e.vp, {e.r, e.g, e.b});
          end
        end
      end
      if (i < 7) drive(px[i], py[i], 1'b1, pm[i], 2'b01, 1'b0, ck[i], 1'b1, ex[i], i);
      else idle();
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL line_step_drain: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_aa_halo();
    exp_t        e;
    int          py [11] = '{0, 127, 126, 128, 125, 129, 126, 127, 255, 256, 1023};
    int          px [11] = '{256, 300, 300, 300, 300, 300, 300, 300, 336, 336, 336};
    logic [1:0]  pe [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01};
    bit          vp [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [23:0] ex [11] = '{24'h0, 24'h00FF00, 24'h007F00, 24'h007F00, 24'h000000, 24'h000000,
                             24'h7FFE00, 24'hFFFF00, 24'h00FF00, 24'h000000, 24'h000000};
    fill(0, 511, 8'd128, 8'd128);
    ram0[40] = 8'd0; ram1[40] = 8'd0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.chk) begin
          n_cmp++;
          if (e.due != cyc || bus.valid_pixel !== e.vp || {bus.r, bus.g, bus.b} !== {e.r, e.g, e.b}) begin
            n_bad++;
            $display("FAIL aa_halo #%0d: got vp=%b rgb=%06x, want vp=%b rgb=%06x", e.id, bus.valid_pixel, {bus.r, bus.g, bus.b}, e.vp, {e.r, e.g, e.b});
          end
        end
      end
      if (i < 11) drive(px[i], py[i], 1'b1, 2, pe[i], 1'b0, i != 0, vp[i], ex[i], i);
      else idle();
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL aa_halo_drain: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_overlap();
    exp_t        e;
    int          px [8] = '{256, 300, 300, 300, 300, 316, 300, 300};
    int          py [8] = '{0, 191, 191, 191, 191, 191, 100, 191};
    bit          pv [8] = '{1, 1, 1, 1, 1, 0, 1, 1};
    int          pm [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [1:0]  pe [8] = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [23:0] ex [8] = '{24'h0, 24'hFFFF00, 24'h00FF00, 24'hFFFF00, 24'h00FF00, 24'h0, 24'h0, 24'h0};
    fill(0, 511, 8'd64, 8'd64);
    ram0[30] = 8'd200;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.chk) begin
          n_cmp++;
          if (e.due != cyc || bus.valid_pixel !== e.vp || {bus.r, bus.g, bus.b} !== {e.r, e.g, e.b}) begin
            n_bad++;
            $display("FAIL overlap #%0d: got vp=%b rgb=%06x, want vp=%b rgb=%06x", e.id, bus.valid_pixel, {bus.r, bus.g, bus.b}, e.vp, {e.r, e.g, e.b});
          end
        end
      end
      if (i < 8) drive(px[i], py[i], pv[i], pm[i], pe[i], 1'b0, i != 0, pv[i], ex[i], i);
      else idle();
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL overlap_drain: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_buffer_select();
    exp_t        e;
    logic [8:0]  want_addr;
    bit          ri;
    int          md;
    logic [23:0] ex;
    fill(0, 255, 8'd64, 8'd64);
    fill(256, 511, 8'd64, 8'd0);
    want_addr = bus.read_address;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (bus.read_address !== want_addr) begin
          n_bad++;
          $display("FAIL buffer_addr step %0d: got %03x, want %03x", i, bus.read_address, want_addr);
        end
      end
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.chk) begin
          n_cmp++;
          if (e.due != cyc || bus.valid_pixel !== e.vp || {bus.r, bus.g, bus.b} !== {e.r, e.g, e.b}) begin
            n_bad++;
            $display("FAIL buffer_select #%0d: got vp=%b rgb=%06x, want vp=%b rgb=%06x", e.id, bus.valid_pixel, {bus.r, bus.g, bus.b}, e.vp, {e.r, e.g, e.b});
          end
        end
      end
      if (i < 8) begin
        ri = i[0];
        md = (i % 4 == 3) ? 3 : 0;
        ex = (md == 3) ? 24'h000000 : (ri ? 24'h00FF00 : 24'hFFFF00);
        drive(300 + 2 * i, 191, 1'b1, md, 2'b11, ri, 1'b1, 1'b1, ex, i);
        want_addr = {ri, 8'(22 + i)};
      end else begin
        idle();
      end
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL buffer_drain: %0d pending, want 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.x = 11'd0; bus.y = 10'd0; bus.valid = 1'b0; bus.mode = 2'd0;
    bus.ch_enable = 2'b00; bus.read_index = 1'b0;
    test_reset();
    test_dot_ramp();
    test_line_step();
    test_aa_halo();
    test_overlap();
    test_buffer_select();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
